mem_port_arbiter: RTL

//  Shares the single-port unified instruction/data memory between two requesters:
//   - port 0: the multicycle core (fetch and load/store).
//   - port 1: the program loader/DMA.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port unified memory: picks a requester, issues one
// access with a fixed read latency and returns a single done pulse to the owner.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter bit          PRIO_MODE   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(MEM_LATENCY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic          owner;
  logic          last_owner;
  logic          we_q;
  logic          err_q;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [CW-1:0] cnt;

  logic          win;
  logic [31:0]   win_addr;

  // Only meaningful when req != 0; with both requesting, round-robin hands the grant
  // to the port that did not own the previous transaction.
  always_comb begin
    win = 1'b0;
    if (PRIO_MODE)
      win = ~req[0];
    else if (req == 2'b11)
      win = ~last_owner;
    else
      win = req[1];
    win_addr = win ? addr1 : addr0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner   <= win;
            we_q    <= we[win];
            addr_q  <= win_addr[31:2];
            wdata_q <= win ? wdata1 : wdata0;
            if (win_addr[1:0] != 2'b00) begin
              err_q <= 1'b1;
              state <= RESP;
            end else begin
              err_q <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= CW'(MEM_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata_q <= mem_rdata;
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          last_owner <= owner;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? {addr_q, 2'b00} : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign done      = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign err       = (state == RESP) & err_q;
  assign rdata     = (state == RESP) ? rdata_q : '0;

endmodule
